// File: rtl/demux_reg.sv
// Registered 1-to-N demultiplexer with a one-entry holding register per output slot.
// Unicast goes to slot sel; broadcast writes every slot at once or waits until all slots are free.
module demux_reg #(
    parameter int switch_bits = 2,
    parameter int data_width  = 8,
    parameter int cnt_width   = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [switch_bits-1:0]                sel,
    input  logic                                  bcast,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [data_width-1:0]                 data_IN,
    output logic [(2**switch_bits)-1:0]           out_valid,
    input  logic [(2**switch_bits)-1:0]           out_ready,
    output logic [(2**switch_bits)*data_width-1:0] data_OUT,
    output logic [cnt_width-1:0]                  xfer_cnt
);

    localparam int n = 2**switch_bits;

    logic [n-1:0] free;
    logic [n-1:0] fill;
    logic         accept;

    // A slot is free when empty or being drained this cycle, so drain and refill can share an edge.
    assign free   = ~out_valid | out_ready;
    assign in_ready = bcast ? (&free) : free[sel];
    assign accept = in_valid & in_ready;

    always_comb begin
        fill = '0;
        for (int i = 0; i < n; i++) begin
            fill[i] = accept & (bcast | (sel == switch_bits'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= '0;
            data_OUT  <= '0;
            xfer_cnt  <= '0;
        end else begin
            for (int i = 0; i < n; i++) begin
                if (fill[i]) begin
                    out_valid[i]                          <= 1'b1;
                    data_OUT[i*data_width +: data_width] <= data_IN;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (accept) begin
                xfer_cnt <= xfer_cnt + cnt_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_reg.sv
// Bench for demux_reg: directed vector table plus hand-written multi-cycle sequences.
// A second instance with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_demux_reg;

    logic        clk;
    logic        rst;
    logic [1:0]  sel;
    logic        bcast;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  data_in;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] data_out;
    logic [15:0] xfer_cnt;

    logic        in_ready_w;
    logic [3:0]  out_valid_w;
    logic [31:0] data_out_w;
    logic [3:0]  xfer_cnt_w;

    int total;
    int bad;

    demux_reg #(.switch_bits(2), .data_width(8), .cnt_width(16)) dut (
        .clk(clk), .rst(rst), .sel(sel), .bcast(bcast), .in_valid(in_valid),
        .in_ready(in_ready), .data_IN(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_OUT(data_out), .xfer_cnt(xfer_cnt)
    );

    demux_reg #(.switch_bits(2), .data_width(8), .cnt_width(4)) dut_w (
        .clk(clk), .rst(rst), .sel(sel), .bcast(bcast), .in_valid(in_valid),
        .in_ready(in_ready_w), .data_IN(data_in), .out_valid(out_valid_w),
        .out_ready(out_ready), .data_OUT(data_out_w), .xfer_cnt(xfer_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        bc;
        logic        iv;
        logic [3:0]  ordy;
        logic [7:0]  d;
        logic        er;
        logic [3:0]  eov;
        logic [31:0] edo;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic b, input logic v,
                         input logic [3:0] r, input logic [7:0] d);
        sel = s; bcast = b; in_valid = v; out_ready = r; data_in = d;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        drive(2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);

        //           sel   bc    iv    ordy     d      er    eov      edo           ecnt
        vt[0]  = '{2'd2, 1'b0, 1'b1, 4'b0000, 8'hA5, 1'b1, 4'b0100, 32'h00A50000, 16'd1};
        vt[1]  = '{2'd2, 1'b0, 1'b1, 4'b0000, 8'hB6, 1'b0, 4'b0100, 32'h00A50000, 16'd1};
        vt[2]  = '{2'd0, 1'b0, 1'b1, 4'b0000, 8'hC7, 1'b1, 4'b0101, 32'h00A500C7, 16'd2};
        vt[3]  = '{2'd1, 1'b0, 1'b0, 4'b0000, 8'h11, 1'b1, 4'b0101, 32'h00A500C7, 16'd2};
        vt[4]  = '{2'd1, 1'b0, 1'b1, 4'b0000, 8'h11, 1'b1, 4'b0111, 32'h00A511C7, 16'd3};
        vt[5]  = '{2'd1, 1'b0, 1'b1, 4'b0010, 8'h22, 1'b1, 4'b0111, 32'h00A522C7, 16'd4};
        vt[6]  = '{2'd3, 1'b0, 1'b0, 4'b0101, 8'h00, 1'b1, 4'b0010, 32'h00A522C7, 16'd4};
        vt[7]  = '{2'd0, 1'b1, 1'b1, 4'b0000, 8'h3C, 1'b0, 4'b0010, 32'h00A522C7, 16'd4};
        vt[8]  = '{2'd0, 1'b1, 1'b1, 4'b0010, 8'h3C, 1'b1, 4'b1111, 32'h3C3C3C3C, 16'd5};
        vt[9]  = '{2'd2, 1'b1, 1'b1, 4'b1110, 8'h77, 1'b0, 4'b0001, 32'h3C3C3C3C, 16'd5};
        vt[10] = '{2'd2, 1'b1, 1'b1, 4'b1111, 8'h77, 1'b1, 4'b1111, 32'h77777777, 16'd6};
        vt[11] = '{2'd0, 1'b0, 1'b0, 4'b1111, 8'h00, 1'b1, 4'b0000, 32'h77777777, 16'd6};
        vt[12] = '{2'd3, 1'b0, 1'b0, 4'b1111, 8'h00, 1'b1, 4'b0000, 32'h77777777, 16'd6};

        check("reset_out_valid", {28'd0, out_valid}, 32'd0);
        check("reset_data_out", data_out, 32'd0);
        check("reset_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        edge_step();
        rst = 1'b1;
        edge_step();

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].sel, vt[i].bc, vt[i].iv, vt[i].ordy, vt[i].d);
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].er});
            edge_step();
            check($sformatf("vec%0d_out_valid", i), {28'd0, out_valid}, {28'd0, vt[i].eov});
            check($sformatf("vec%0d_data_out", i), data_out, vt[i].edo);
            check($sformatf("vec%0d_xfer_cnt", i), {16'd0, xfer_cnt}, {16'd0, vt[i].ecnt});
        end

        // Stream 10 words into slot 1 with its consumer always ready.
        for (int k = 0; k < 10; k++) begin
            drive(2'd1, 1'b0, 1'b1, 4'b0010, 8'h50 + 8'(k));
            check($sformatf("stream%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
            edge_step();
            check($sformatf("stream%0d_slot1", k), {24'd0, data_out[15:8]}, {24'd0, 8'h50 + 8'(k)});
            check($sformatf("stream%0d_out_valid", k), {28'd0, out_valid}, 32'h2);
        end
        check("stream_xfer_cnt", {16'd0, xfer_cnt}, 32'd16);

        // Backpressure: slot 3 full and blocked for 5 cycles.
        drive(2'd3, 1'b0, 1'b1, 4'b0000, 8'hE1);
        edge_step();
        check("bp_first_cnt", {16'd0, xfer_cnt}, 32'd17);
        for (int k = 0; k < 5; k++) begin
            drive(2'd3, 1'b0, 1'b1, 4'b0000, 8'hE2);
            check($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            edge_step();
            check($sformatf("bp%0d_slot3", k), {24'd0, data_out[31:24]}, 32'hE1);
        end
        drive(2'd3, 1'b0, 1'b1, 4'b1000, 8'hE2);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        edge_step();
        check("bp_release_slot3", {24'd0, data_out[31:24]}, 32'hE2);
        check("bp_release_valid", {31'd0, out_valid[3]}, 32'd1);
        drive(2'd3, 1'b0, 1'b0, 4'b0000, 8'h00);
        edge_step();
        check("bp_single_increment", {16'd0, xfer_cnt}, 32'd18);

        // Fill slot 1 too, then reset asynchronously between edges.
        drive(2'd1, 1'b0, 1'b1, 4'b0000, 8'hAB);
        edge_step();
        check("pre_reset_out_valid", {28'd0, out_valid}, 32'hA);
        drive(2'd0, 1'b0, 1'b0, 4'b0000, 8'h00);
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_out_valid", {28'd0, out_valid}, 32'd0);
        check("async_reset_data_out", data_out, 32'd0);
        check("async_reset_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        edge_step();

        // Counter wrap on the 4-bit instance.
        for (int k = 0; k < 15; k++) begin
            drive(2'd0, 1'b0, 1'b1, 4'b0001, 8'(k));
            edge_step();
        end
        check("wrap_cnt_15", {28'd0, xfer_cnt_w}, 32'd15);
        check("wide_cnt_15", {16'd0, xfer_cnt}, 32'd15);
        for (int k = 0; k < 2; k++) begin
            drive(2'd0, 1'b0, 1'b1, 4'b0001, 8'hF0 + 8'(k));
            edge_step();
        end
        check("wrap_cnt_17", {28'd0, xfer_cnt_w}, 32'd1);
        check("wide_cnt_17", {16'd0, xfer_cnt}, 32'd17);
        check("wrap_slot0", {24'd0, data_out_w[7:0]}, 32'hF1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
